hub75_scan_reader: RTL and testbench

- Read-side consumer of the double-buffered framebuffer RAM (16-bit RGB565 pixels; 10-bit read address; top and bottom half-panel words returned together).
- Walks the frame row by row and bit-plane by bit-plane, and shifts pixel bits out to a 64x32 HUB75 panel.
- Generates the panel's CLK, LAT, OE and row address, using binary-coded modulation for brightness.
- Owns the buffer_toggle line, flipping buffers only at frame boundaries when the writer requests it.

---
 rtl/hub75_scan_reader_if.sv | 35 +++
 rtl/hub75_scan_reader.sv | 144 ++++++++++++++
 tb/tb_hub75_scan_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/hub75_scan_reader_if.sv
// Framebuffer read port, swap handshake and HUB75 panel pins of the scan reader.
// The master side is the scan reader; the slave side is the RAM/writer/panel.
interface hub75_scan_reader_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] read_addr;
  logic              read_en;
  logic [15:0]       read_data_top;
  logic [15:0]       read_data_bottom;
  logic              buffer_toggle;
  logic              swap_req;
  logic              swap_ack;
  logic              frame_start;
  logic [1:0]        hub75_red;
  logic [1:0]        hub75_green;
  logic [1:0]        hub75_blue;
  logic              hub75_clk;
  logic              hub75_lat;
  logic              hub75_oe_n;
  logic [3:0]        hub75_row;

  modport master (
    output read_addr, read_en, buffer_toggle, swap_ack, frame_start,
           hub75_red, hub75_green, hub75_blue, hub75_clk, hub75_lat,
           hub75_oe_n, hub75_row,
    input  read_data_top, read_data_bottom, swap_req
  );

  modport slave (
    input  read_addr, read_en, buffer_toggle, swap_ack, frame_start,
           hub75_red, hub75_green, hub75_blue, hub75_clk, hub75_lat,
           hub75_oe_n, hub75_row,
    output read_data_top, read_data_bottom, swap_req
  );
endinterface

// File: rtl/hub75_scan_reader.sv
// HUB75 scan engine: shifts bit-planes of RGB565 framebuffer rows to the panel
// with binary-coded-modulation OE timing, and flips buffers at frame ends.
module hub75_scan_reader #(
  parameter int COLS      = 64,
  parameter int HALF_ROWS = 16,
  parameter int PLANES    = 5,
  parameter int BASE_TIME = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  hub75_scan_reader_if.master bus
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(HALF_ROWS);
  localparam int PL_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int DW    = $clog2(BASE_TIME << (PLANES - 1)) + 1;

  typedef enum logic [1:0] {S_SHIFT = 2'd0, S_LATCH = 2'd1, S_DISPLAY = 2'd2} state_t;

  state_t           r_state, w_next;
  logic             r_run, r_pend, r_tog;
  logic [1:0]       r_phase;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row, r_hrow;
  logic [PL_W-1:0]  r_plane;
  logic [DW-1:0]    r_dcnt, w_dtime;
  logic [1:0]       r_red, r_green, r_blue;
  logic             w_shift_done, w_disp_done, w_last_plane, w_eof, w_swap;
  logic [3:0]       w_ir, w_ig, w_ib;

  assign w_dtime      = DW'(BASE_TIME) << r_plane;
  assign w_shift_done = (r_state == S_SHIFT) && (r_phase == 2'd2) && (r_col == COL_W'(COLS - 1));
  assign w_disp_done  = (r_state == S_DISPLAY) && (r_dcnt == w_dtime - DW'(1));
  assign w_last_plane = (r_plane == PL_W'(PLANES - 1));
  assign w_eof        = r_run && w_disp_done && w_last_plane && (r_row == ROW_W'(HALF_ROWS - 1));
  // A request landing on the frame-end cycle itself swaps immediately.
  assign w_swap       = w_eof && (r_pend || bus.swap_req);

  // Plane p of each channel: top 5 bits of R/G/B in RGB565.
  assign w_ir = 4'd11 + 4'(r_plane);
  assign w_ig = 4'd6 + 4'(r_plane);
  assign w_ib = 4'(r_plane);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_SHIFT;
    else if (r_run) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SHIFT:   if (w_shift_done) w_next = S_LATCH;
      S_LATCH:   w_next = S_DISPLAY;
      S_DISPLAY: if (w_disp_done) w_next = S_SHIFT;
      default:   w_next = S_SHIFT;
    endcase
  end

  // r_run holds the panel blank for the first edge after reset release.
  always_comb begin
    bus.read_en     = 1'b0;
    bus.hub75_clk   = 1'b0;
    bus.hub75_lat   = 1'b0;
    bus.hub75_oe_n  = 1'b1;
    bus.frame_start = 1'b0;
    if (r_run) begin
      case (r_state)
        S_SHIFT: begin
          bus.read_en     = (r_phase == 2'd0);
          bus.hub75_clk   = (r_phase == 2'd2);
          bus.frame_start = (r_phase == 2'd0) && (r_col == '0) && (r_row == '0) && (r_plane == '0);
        end
        S_LATCH:   bus.hub75_lat  = 1'b1;
        S_DISPLAY: bus.hub75_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.read_addr     = r_run ? {r_row, r_col} : '0;
  assign bus.buffer_toggle = r_tog ^ w_swap;
  assign bus.swap_ack      = w_swap;
  assign bus.hub75_red     = r_red;
  assign bus.hub75_green   = r_green;
  assign bus.hub75_blue    = r_blue;
  assign bus.hub75_row     = r_hrow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run   <= 1'b0;
      r_pend  <= 1'b0;
      r_tog   <= 1'b0;
      r_phase <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_hrow  <= '0;
      r_plane <= '0;
      r_dcnt  <= '0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_swap) begin
          r_tog  <= ~r_tog;
          r_pend <= 1'b0;
        end else if (bus.swap_req) begin
          r_pend <= 1'b1;
        end
        case (r_state)
          S_SHIFT: begin
            if (r_phase == 2'd2) begin
              r_phase <= '0;
              r_col   <= r_col + COL_W'(1);
            end else begin
              r_phase <= r_phase + 2'd1;
            end
            if (r_phase == 2'd1) begin
              r_red   <= {bus.read_data_bottom[w_ir], bus.read_data_top[w_ir]};
              r_green <= {bus.read_data_bottom[w_ig], bus.read_data_top[w_ig]};
              r_blue  <= {bus.read_data_bottom[w_ib], bus.read_data_top[w_ib]};
            end
            if (w_shift_done) r_hrow <= r_row;
          end
          S_LATCH: r_dcnt <= '0;
          S_DISPLAY: begin
            if (w_disp_done) begin
              if (w_last_plane) begin
                r_plane <= '0;
                r_row   <= r_row + ROW_W'(1);
              end else begin
                r_plane <= r_plane + PL_W'(1);
              end
            end else begin
              r_dcnt <= r_dcnt + DW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hub75_scan_reader.sv
// Directed bench for hub75_scan_reader: cycle-accurate walk of rows/frames
// against hand-computed latch/OE positions, pixel bits and swap timing.
module tb_hub75_scan_reader;
  localparam int ROW_CYC = 1213;

  logic clk = 1'b0;
  logic reset_n;
  int   checks, fails, cyc, swap_a, swap_b, ack_cyc;
  logic exp_tog, ram_mode;

  hub75_scan_reader_if bus();

  hub75_scan_reader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // One-cycle registered RAM; mode 0 = solid red/blue, mode 1 = plane-selective bits.
  always @(posedge clk) begin
    if (bus.read_en) begin
      bus.read_data_top    <= ram_mode ? 16'h0841 : 16'hF800;
      bus.read_data_bottom <= ram_mode ? 16'h1082 : 16'h001F;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_at(input int p);
    case (p)
      0: return 192;
      1: return 393;
      2: return 602;
      3: return 827;
      default: return 1084;
    endcase
  endfunction

  function automatic int oe_len(input int p);
    case (p)
      0: return 8;
      1: return 16;
      2: return 32;
      3: return 64;
      default: return 128;
    endcase
  endfunction

  function automatic logic [5:0] exp_rgb(input logic mode, input int p);
    if (!mode) return 6'b01_00_10;
    if (p == 0) return 6'b01_01_01;
    if (p == 1) return 6'b10_10_10;
    return 6'b00_00_00;
  endfunction

  task automatic scan_row(input int r, input logic mode, input int ncyc);
    int nl, run, nrun, clkr, k;
    int clk_bad, rgb_bad, addr_bad, row_bad, fs_bad, sw_bad, lat_bad;
    int runs [5];
    logic pclk;
    nl = 0; run = 0; nrun = 0; clkr = 0; k = 0; pclk = 1'b0;
    clk_bad = 0; rgb_bad = 0; addr_bad = 0; row_bad = 0; fs_bad = 0; sw_bad = 0; lat_bad = 0;
    for (int p = 0; p < 5; p++) runs[p] = 0;
    ram_mode = mode;
    for (int i = 0; i < ncyc; i++) begin
      bus.swap_req = (cyc == swap_a) || (cyc == swap_b);
      #1;
      if (bus.frame_start !== ((r == 0) && (i == 0))) fs_bad++;
      if (cyc == ack_cyc) exp_tog = ~exp_tog;
      if (bus.swap_ack !== (cyc == ack_cyc) || bus.buffer_toggle !== exp_tog) sw_bad++;
      if (bus.read_en) begin
        if (bus.read_addr !== 10'(r * 64 + k)) addr_bad++;
        k++;
      end
      if (bus.hub75_clk && !pclk) begin
        clkr++;
        if ({bus.hub75_red, bus.hub75_green, bus.hub75_blue} !== exp_rgb(mode, nl)) rgb_bad++;
      end
      pclk = bus.hub75_clk;
      if (bus.hub75_lat) begin
        if (nl > 4 || i != lat_at(nl)) lat_bad++;
        if (clkr != 64 || k != 64) clk_bad++;
        clkr = 0; k = 0; nl++;
      end
      if ((bus.hub75_lat || !bus.hub75_oe_n) && bus.hub75_row !== 4'(r)) row_bad++;
      if (!bus.hub75_oe_n) run++;
      else if (run > 0) begin
        if (nrun < 5) runs[nrun] = run;
        nrun++;
        run = 0;
      end
      tick();
      cyc++;
    end
    chk($sformatf("r%0d_frame_start", r), fs_bad, 0);
    chk($sformatf("r%0d_swap", r), sw_bad, 0);
    chk($sformatf("r%0d_addr", r), addr_bad, 0);
    chk($sformatf("r%0d_rgb", r), rgb_bad, 0);
    chk($sformatf("r%0d_clk_count", r), clk_bad, 0);
    chk($sformatf("r%0d_lat_pos", r), lat_bad, 0);
    chk($sformatf("r%0d_panel_row", r), row_bad, 0);
    if (ncyc == ROW_CYC) begin
      if (run > 0) begin
        if (nrun < 5) runs[nrun] = run;
        nrun++;
      end
      chk($sformatf("r%0d_latches", r), nl, 5);
      chk($sformatf("r%0d_oe_runs", r), nrun, 5);
      for (int p = 0; p < 5; p++) chk($sformatf("r%0d_oe_len%0d", r, p), runs[p], oe_len(p));
    end
  endtask

  task automatic chk_cycle0(input string tag);
    chk({tag, "_read_en"}, bus.read_en, 1);
    chk({tag, "_read_addr"}, bus.read_addr, 0);
    chk({tag, "_frame_start"}, bus.frame_start, 1);
    chk({tag, "_oe_n"}, bus.hub75_oe_n, 1);
  endtask

  initial begin
    checks = 0; fails = 0; cyc = 0;
    swap_a = -1; swap_b = -1; ack_cyc = -1;
    exp_tog = 1'b0; ram_mode = 1'b0;
    reset_n = 1'b0;
    bus.swap_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_oe_n", bus.hub75_oe_n, 1);
    chk("rst_read_en", bus.read_en, 0);
    chk("rst_read_addr", bus.read_addr, 0);
    chk("rst_toggle", bus.buffer_toggle, 0);
    chk("rst_misc", {bus.frame_start, bus.swap_ack, bus.hub75_lat, bus.hub75_clk, bus.hub75_row}, 0);
    chk("rst_rgb", {bus.hub75_red, bus.hub75_green, bus.hub75_blue}, 0);
    reset_n = 1'b1;
    tick();
    chk_cycle0("c0");

    // Frame 1: two requests collapse into one swap at the frame-end cycle.
    swap_a = 5000; swap_b = 6000; ack_cyc = 19407;
    for (int r = 0; r < 16; r++) scan_row(r, r != 0, ROW_CYC);
    chk("f2_frame_start", bus.frame_start, 1);
    chk("f2_toggle", bus.buffer_toggle, 1);

    // Frame 2: no requests, buffer select holds.
    swap_a = -1; swap_b = -1; ack_cyc = -1;
    for (int r = 0; r < 16; r++) scan_row(r, r != 0, ROW_CYC);

    // Frame 3: pending request, then reset in the middle of plane-0 DISPLAY.
    swap_a = cyc + 10;
    scan_row(0, 1'b0, 195);
    chk("pre_rst_oe_n", bus.hub75_oe_n, 0);
    chk("pre_rst_toggle", bus.buffer_toggle, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_oe_n", bus.hub75_oe_n, 1);
    chk("mid_rst_toggle", bus.buffer_toggle, 0);
    chk("mid_rst_read_en", bus.read_en, 0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick();
    cyc = 0; exp_tog = 1'b0;
    chk_cycle0("rc0");

    // Frame 4: pending discarded; a request on the frame-end cycle swaps at once.
    swap_a = 19407; swap_b = -1; ack_cyc = 19407;
    for (int r = 0; r < 16; r++) scan_row(r, r != 0, ROW_CYC);
    chk("f5_frame_start", bus.frame_start, 1);
    chk("f5_toggle", bus.buffer_toggle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
